down_counter_scheduler: RTL and testbench
=========================================

Name: down_counter_scheduler

Overview:
- Shares one external `loadable_down_counter_8bit` instance among NUM_REQ requesters, each asking for a timed delay.
- Arbitrates round-robin, loads the winner's delay into the counter, enables countdown and watches tc.
- Returns a one-cycle done pulse to the winning requester.
- Sits between the timer clients and the counter; it is the only driver of the counter's load, enable and data_in.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, delay/count width; matches the counter data width.
- IDW, $clog2(NUM_REQ), width of the grant index.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request.
- req_delay  input  NUM_REQ*WIDTH  delay for requester i, in slice [i*WIDTH +: WIDTH].
- req_ready  output  NUM_REQ  one-hot accept; a transfer occurs when req_valid[i] && req_ready[i].
- done  output  NUM_REQ  one-hot, one-cycle pulse when the granted delay expires.
- busy  output  1  high in LOAD, RUN and DONE.
- grant_id  output  IDW  index of the current or last granted requester.
- cnt_load  output  1  drives the counter's load.
- cnt_enable  output  1  drives the counter's enable.
- cnt_data  output  WIDTH  drives the counter's data_in.
- cnt_tc  input  1  counter terminal count (count==0).

Behaviour:
- Reset (asynchronous, any state) gives: state=IDLE, rr pointer=0, grant_id=0, delay register=0. All outputs 0 except those derived from state (all inactive).
- States and transitions:
  - IDLE: if any req_valid, the combinational round-robin pick g is found by searching indices ptr, ptr+1 … ptr+NUM_REQ-1 (mod NUM_REQ). req_ready = onehot(g) in this cycle only. On the edge: latch req_delay[g], set grant_id=g, set ptr=(g+1) mod NUM_REQ, go to LOAD. No valid: req_ready=0, stay in IDLE.
  - LOAD: cnt_load=1, cnt_data=latched delay, cnt_enable=0. Always goes to RUN next cycle.
  - RUN: cnt_enable = !cnt_tc (combinational); cnt_load=0. If cnt_tc=1, go to DONE and do not enable that cycle. Otherwise stay in RUN.
  - DONE: done[grant_id]=1 for exactly one cycle. Go to IDLE.
- Timing: with the request accepted in cycle 0, LOAD is cycle 1 and RUN begins in cycle 2 with count=D. done is asserted in cycle D+3.
  - D=0 gives done in cycle 3.
  - D=255 gives done in cycle 258.
  - No wrap-around: the counter never decrements below 0 because enable is gated by tc.
- cnt_data holds the latched delay in all states; only cnt_load qualifies it.
- req_ready is asserted only in IDLE. Requests arriving while busy wait; req_valid is held by the requester until accepted.
- Back-to-back: after DONE the FSM spends one IDLE cycle arbitrating. Minimum spacing between accepts is D+4 cycles.
- A requester deasserting req_valid before acceptance is simply not granted; there is no error.
- Simultaneous requests: the lowest index at or after ptr wins. A continuously requesting client is served at least once every NUM_REQ grants.
- Reset mid-RUN: returns to IDLE immediately. No done pulse is produced. The counter itself is reset separately by the same rst.
- grant_id is stable from accept until the next accept.

Decomposition:
- Shared package `down_counter_sched_pkg`:
  - state enum {IDLE, LOAD, RUN, DONE};
  - default constants NUM_REQ_DEF=4, WIDTH_DEF=8.
- One sub-module: `rr_arbiter`, which is combinational. Inputs: req vector, ptr. Outputs: one-hot grant, grant index, any_req.
- The pointer register and FSM stay in the top level.

Test Plan:
- Reset: rst=1 for 2 cycles with req_valid=4'b1111 -> req_ready=0, done=0, busy=0, cnt_load=0, cnt_enable=0. After release, first grant goes to requester 0.
- Single request: req0 delay=5 accepted at cycle 0 -> cnt_load=1 with cnt_data=5 at cycle 1; count 5,4,3,2,1,0 across cycles 2..7; cnt_enable low in cycle 7; done[0] pulse at cycle 8 only.
- Zero delay: req2 delay=0 -> done[2] exactly 3 cycles after accept; cnt_enable never asserted.
- Round-robin: all four valid with delay=1 continuously -> grant order 0,1,2,3,0; each done one-hot matches grant_id; accepts spaced 5 cycles apart.
- Busy hold-off: req1 raised during RUN of req0 -> req_ready[1] stays 0 until the IDLE cycle after done[0], then accepted.
- Reset mid-run: req3 delay=200, rst pulsed at count=100 -> immediate IDLE, no done[3], busy=0; next grant starts at requester 0.

Source files
------------

// File: rtl/down_counter_sched_pkg.sv
// Shared types and default sizing for the down-counter scheduler.
package down_counter_sched_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned WIDTH_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/down_counter_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDW-1:0]     grant_idx_o,
  output logic               any_req_o
);

  logic [IDW-1:0] sel;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_req_o   = 1'b0;
    sel         = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      sel = IDW'((32'(ptr_i) + off) % NUM_REQ);
      if (!any_req_o && req_i[sel]) begin
        any_req_o    = 1'b1;
        grant_idx_o  = sel;
        grant_o[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/down_counter_scheduler.sv
// Time-shares one loadable down counter among NUM_REQ delay requesters,
// round-robin, returning a one-cycle done pulse to the winner.
module down_counter_scheduler
  import down_counter_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_delay,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [IDW-1:0]           grant_id,
  output logic                     cnt_load,
  output logic                     cnt_enable,
  output logic [WIDTH-1:0]         cnt_data,
  input  logic                     cnt_tc
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic [WIDTH-1:0] delay_q, delay_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDW-1:0]     arb_idx;
  logic               arb_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (arb_grant),
    .grant_idx_o (arb_idx),
    .any_req_o   (arb_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
      delay_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      delay_q    <= delay_d;
    end
  end

  // Next state plus state-decoded outputs; enable is gated by tc so the counter never wraps.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    delay_d    = delay_q;
    req_ready  = '0;
    done       = '0;
    busy       = 1'b0;
    cnt_load   = 1'b0;
    cnt_enable = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          req_ready  = rst ? '0 : arb_grant;
          delay_d    = req_delay[32'(arb_idx)*WIDTH +: WIDTH];
          grant_id_d = arb_idx;
          ptr_d      = (arb_idx == IDW'(NUM_REQ-1)) ? '0 : arb_idx + IDW'(1);
          state_d    = LOAD;
        end
      end
      LOAD: begin
        busy     = 1'b1;
        cnt_load = 1'b1;
        state_d  = RUN;
      end
      RUN: begin
        busy       = 1'b1;
        cnt_enable = !cnt_tc;
        if (cnt_tc) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = NUM_REQ'(1) << grant_id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_id = grant_id_q;
  assign cnt_data = delay_q;

endmodule

// File: tb/tb_down_counter_scheduler.sv
// Bench for down_counter_scheduler: models the external counter, scoreboards done pulses.
module tb_down_counter_scheduler;

  localparam int unsigned NR = 4;
  localparam int unsigned W  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR*W-1:0] req_delay;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   done;
  logic            busy;
  logic [1:0]      grant_id;
  logic            cnt_load;
  logic            cnt_enable;
  logic [W-1:0]    cnt_data;
  logic            cnt_tc;

  logic [W-1:0]    cnt_m;
  int              cyc = 0;
  int              checks = 0;
  int              errors = 0;

  typedef struct {int id; int due;} exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0] valid;
    logic [7:0] delay;
    int         exp_grant;
  } vec_t;
  vec_t vecs[8];

  down_counter_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_delay  (req_delay),
    .req_ready  (req_ready),
    .done       (done),
    .busy       (busy),
    .grant_id   (grant_id),
    .cnt_load   (cnt_load),
    .cnt_enable (cnt_enable),
    .cnt_data   (cnt_data),
    .cnt_tc     (cnt_tc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model of the external loadable_down_counter_8bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             cnt_m <= '0;
    else if (cnt_load)   cnt_m <= cnt_data;
    else if (cnt_enable) cnt_m <= cnt_m - 8'd1;
  end
  assign cnt_tc = (cnt_m == 8'd0);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int oh2idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Scoreboard: push on accept, pop and compare on done.
  always @(negedge clk) begin
    if (!rst) begin
      if (|(req_valid & req_ready)) begin
        exp_t e;
        e.id  = oh2idx(req_valid & req_ready);
        e.due = cyc + int'(req_delay[e.id*W +: W]) + 3;
        sb.push_back(e);
      end
      if (|done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_vector", 64'(done), 64'(4'b0001 << e.id));
          chk("done_cycle", 64'(cyc), 64'(e.due));
        end
      end
      if (cnt_enable) chk("enable_at_tc", 64'(cnt_tc), 64'(0));
    end
  end

  task automatic wait_accept(output int acc, output logic [3:0] rdy);
    int n = 0;
    @(negedge clk);
    while (!(|(req_valid & req_ready)) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) chk("accept_timeout", 64'(1), 64'(0));
    acc = cyc;
    rdy = req_ready;
  endtask

  task automatic wait_done(output int dc);
    int n = 0;
    @(negedge clk);
    while (!(|done) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) chk("done_timeout", 64'(1), 64'(0));
    dc = cyc;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_cnt_load"}, 64'(cnt_load), 64'(0));
    chk({tag, "_cnt_enable"}, 64'(cnt_enable), 64'(0));
    chk({tag, "_grant_id"}, 64'(grant_id), 64'(0));
  endtask

  initial begin
    int acc, dc, prev_acc;
    logic [3:0] rdy;

    vecs[0] = '{4'b1111, 8'd3,   3};
    vecs[1] = '{4'b0110, 8'd2,   1};
    vecs[2] = '{4'b0011, 8'd4,   0};
    vecs[3] = '{4'b1001, 8'd1,   3};
    vecs[4] = '{4'b1000, 8'd255, 3};
    vecs[5] = '{4'b0101, 8'd0,   0};
    vecs[6] = '{4'b0101, 8'd6,   2};
    vecs[7] = '{4'b0010, 8'd9,   1};

    // Reset with all requests pending.
    rst = 1'b1;
    req_valid = 4'b1111;
    req_delay = {4{8'd7}};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;
    wait_accept(acc, rdy);
    chk("first_grant", 64'(oh2idx(rdy)), 64'(0));
    @(posedge clk); #1 req_valid = '0;
    wait_done(dc);

    // Single request, delay 5, cycle by cycle.
    @(posedge clk); #1 req_valid = 4'b0001; req_delay = {4{8'd5}};
    wait_accept(acc, rdy);
    chk("single_grant", 64'(oh2idx(rdy)), 64'(0));
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    chk("single_load", 64'(cnt_load), 64'(1));
    chk("single_data", 64'(cnt_data), 64'(5));
    chk("single_load_en", 64'(cnt_enable), 64'(0));
    chk("single_busy", 64'(busy), 64'(1));
    for (int k = 2; k <= 7; k++) begin
      @(negedge clk);
      chk("single_count", 64'(cnt_m), 64'(7 - k));
      chk("single_enable", 64'(cnt_enable), 64'(k != 7));
      chk("single_no_load", 64'(cnt_load), 64'(0));
    end
    @(negedge clk);
    chk("single_done", 64'(done), 64'(4'b0001));
    chk("single_done_cyc", 64'(cyc - acc), 64'(8));
    @(negedge clk);
    chk("single_done_once", 64'(done), 64'(0));
    chk("single_idle", 64'(busy), 64'(0));

    // Zero delay on requester 2.
    @(posedge clk); #1 req_valid = 4'b0100; req_delay = {4{8'd0}};
    wait_accept(acc, rdy);
    chk("zero_grant", 64'(oh2idx(rdy)), 64'(2));
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    chk("zero_load", 64'(cnt_load), 64'(1));
    chk("zero_en1", 64'(cnt_enable), 64'(0));
    @(negedge clk);
    chk("zero_en2", 64'(cnt_enable), 64'(0));
    @(negedge clk);
    chk("zero_done", 64'(done), 64'(4'b0100));
    chk("zero_done_cyc", 64'(cyc - acc), 64'(3));

    // Table-driven arbitration and delay vectors.
    foreach (vecs[i]) begin
      @(posedge clk); #1 req_valid = vecs[i].valid; req_delay = {4{vecs[i].delay}};
      wait_accept(acc, rdy);
      chk("vec_grant", 64'(oh2idx(rdy)), 64'(vecs[i].exp_grant));
      @(posedge clk); #1 req_valid = '0;
      @(negedge clk);
      chk("vec_grant_id", 64'(grant_id), 64'(vecs[i].exp_grant));
      wait_done(dc);
      chk("vec_latency", 64'(dc - acc), 64'(int'(vecs[i].delay) + 3));
      chk("vec_grant_id_hold", 64'(grant_id), 64'(vecs[i].exp_grant));
    end

    // Busy hold-off: req1 arrives while req0 is counting.
    @(posedge clk); #1 req_valid = 4'b0001; req_delay = {4{8'd4}};
    wait_accept(acc, rdy);
    chk("hold_grant0", 64'(oh2idx(rdy)), 64'(0));
    @(posedge clk); #1 req_valid = '0;
    repeat (3) @(posedge clk);
    #1 req_valid = 4'b0010; req_delay = {4{8'd3}};
    begin
      int n = 0;
      @(negedge clk);
      while (!(|done) && n < 50) begin
        chk("hold_ready_low", 64'(req_ready), 64'(0));
        @(negedge clk);
        n++;
      end
      chk("hold_ready_in_done", 64'(req_ready), 64'(0));
      dc = cyc;
    end
    wait_accept(acc, rdy);
    chk("hold_grant1", 64'(oh2idx(rdy)), 64'(1));
    chk("hold_accept_cyc", 64'(acc - dc), 64'(1));
    @(posedge clk); #1 req_valid = '0;
    wait_done(dc);

    // Round-robin after a fresh reset: all requesters continuously valid.
    @(posedge clk); #1 rst = 1'b1; sb.delete();
    req_valid = 4'b1111; req_delay = {4{8'd1}};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rr_reset");
    @(posedge clk); #1 rst = 1'b0;
    prev_acc = 0;
    for (int i = 0; i < 5; i++) begin
      wait_accept(acc, rdy);
      chk("rr_order", 64'(oh2idx(rdy)), 64'(i % 4));
      if (i > 0) chk("rr_spacing", 64'(acc - prev_acc), 64'(5));
      prev_acc = acc;
    end
    @(posedge clk); #1 req_valid = '0;
    wait_done(dc);

    // Reset in the middle of a long countdown.
    @(posedge clk); #1 req_valid = 4'b1000; req_delay = {4{8'd200}};
    wait_accept(acc, rdy);
    chk("mid_grant", 64'(oh2idx(rdy)), 64'(3));
    @(posedge clk); #1 req_valid = '0;
    begin
      int n = 0;
      @(negedge clk);
      while (cnt_m != 8'd100 && n < 400) begin
        @(negedge clk);
        n++;
      end
      chk("mid_reach_100", 64'(cnt_m), 64'(100));
    end
    chk("mid_busy_before", 64'(busy), 64'(1));
    @(posedge clk); #1 rst = 1'b1; sb.delete();
    @(negedge clk);
    check_reset_outputs("mid_reset");
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("mid_no_done", 64'(done), 64'(0));
    end
    @(posedge clk); #1 req_valid = 4'b1111; req_delay = {4{8'd2}};
    wait_accept(acc, rdy);
    chk("mid_next_grant", 64'(oh2idx(rdy)), 64'(0));
    @(posedge clk); #1 req_valid = '0;
    wait_done(dc);
    repeat (2) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
